// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage-register state encoding, the NOP constant
// and the payload layout carried across each stage boundary.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Encoded so the state value doubles as the occupancy count.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, flush-to-NOP
// and a saturating stall-cycle counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = DATA_W'(NOP_INSTR),
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire, out_fire;

    // Handshake outputs come from the state register only.
    assign out_valid = (state_q != PS_EMPTY);
    assign in_ready  = (state_q != PS_TWO);
    assign out_data  = main_q;
    assign occ       = state_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = PS_EMPTY;
            main_d  = FLUSH_VAL;
            skid_d  = FLUSH_VAL;
        end else begin
            unique case (state_q)
                PS_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = PS_TWO;
                    end else if (out_fire) begin
                        state_d = PS_EMPTY;
                    end
                end
                PS_TWO: begin
                    // Skid always holds the younger beat, so it promotes to main.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = PS_ONE;
                    end
                end
                default: state_d = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PS_EMPTY;
            main_q  <= FLUSH_VAL;
            skid_q  <= FLUSH_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed vector table plus hand-written sequences for saturation and ordering.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall_cnt;

    // DUT B: narrow stall counter for saturation
    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [2:0]  b_stall_cnt;

    pipe_stage_elastic dut_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .occ(a_occ), .stall_cnt(a_stall_cnt)
    );

    pipe_stage_elastic #(.CNT_W(3)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .occ(b_occ), .stall_cnt(b_stall_cnt)
    );

    typedef struct {
        logic        rst, flush, iv;
        logic [31:0] din;
        logic        ordy;
        logic        e_ov, e_ir;
        logic [31:0] e_data;
        logic [1:0]  e_occ;
        logic [15:0] e_st;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic flush, input logic iv,
                                input logic [31:0] din, input logic ordy,
                                input logic e_ov, input logic e_ir, input logic [31:0] e_data,
                                input logic [1:0] e_occ, input logic [15:0] e_st);
        vec_t v;
        v.rst = rst; v.flush = flush; v.iv = iv; v.din = din; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_data = e_data; v.e_occ = e_occ; v.e_st = e_st;
        return v;
    endfunction

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic [31:0] seq_data;
    int          got;

    initial begin
        a_rst = 1; a_flush = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 1;
        b_rst = 1; b_flush = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 1;

        //             rst flush iv din          ordy | ov ir data         occ st
        vecs.push_back(mk(1, 0, 1, 32'h55,  1,  0, 1, 32'h13,  0, 0));  // reset, in_valid ignored
        vecs.push_back(mk(1, 0, 1, 32'h55,  1,  0, 1, 32'h13,  0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h100, 1,  1, 1, 32'h100, 1, 0));  // streaming
        vecs.push_back(mk(0, 0, 1, 32'h104, 1,  1, 1, 32'h104, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h108, 1,  1, 1, 32'h108, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   1,  0, 1, 32'h108, 0, 0));  // drain, main holds
        vecs.push_back(mk(0, 0, 1, 32'hA,   1,  1, 1, 32'hA,   1, 0));
        vecs.push_back(mk(0, 0, 1, 32'hB,   0,  1, 0, 32'hA,   2, 1));  // skid absorbs B
        vecs.push_back(mk(0, 0, 1, 32'hFF,  0,  1, 0, 32'hA,   2, 2));  // not accepted
        vecs.push_back(mk(0, 0, 0, 32'h0,   1,  1, 1, 32'hB,   1, 2));  // A out, B promoted
        vecs.push_back(mk(0, 0, 0, 32'h0,   1,  0, 1, 32'hB,   0, 2));  // B out
        vecs.push_back(mk(0, 0, 1, 32'hC,   0,  1, 1, 32'hC,   1, 2));
        for (int i = 0; i < 5; i++)                                      // 5 stall cycles
            vecs.push_back(mk(0, 0, 0, 32'h0, 0, 1, 1, 32'hC, 1, 16'(3 + i)));
        vecs.push_back(mk(0, 0, 1, 32'hD,   0,  1, 0, 32'hC,   2, 8));
        vecs.push_back(mk(0, 1, 1, 32'hE,   0,  0, 1, 32'h13,  0, 9));  // flush drops E too
        vecs.push_back(mk(0, 0, 1, 32'hF,   1,  1, 1, 32'hF,   1, 9));  // accept right after flush
        vecs.push_back(mk(0, 0, 1, 32'h10,  0,  1, 0, 32'hF,   2, 10));
        vecs.push_back(mk(1, 1, 1, 32'h11,  0,  0, 1, 32'h13,  0, 0));  // reset beats flush
        vecs.push_back(mk(0, 0, 0, 32'h0,   1,  0, 1, 32'h13,  0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            a_rst = vecs[i].rst; a_flush = vecs[i].flush; a_in_valid = vecs[i].iv;
            a_in_data = vecs[i].din; a_out_ready = vecs[i].ordy;
            @(posedge clk); #1;
            check("out_valid", i, 32'(a_out_valid), 32'(vecs[i].e_ov));
            check("in_ready",  i, 32'(a_in_ready),  32'(vecs[i].e_ir));
            check("out_data",  i, a_out_data,       vecs[i].e_data);
            check("occ",       i, 32'(a_occ),       32'(vecs[i].e_occ));
            check("stall_cnt", i, 32'(a_stall_cnt), 32'(vecs[i].e_st));
        end

        // Saturation with a 3-bit counter
        @(negedge clk); b_rst = 0; b_in_valid = 1; b_in_data = 32'h5; b_out_ready = 0;
        @(negedge clk); b_in_valid = 0;
        check("sat_load", 0, 32'(b_stall_cnt), 0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 3 || c == 7 || c == 8 || c == 10)
                check("sat_cnt", c, 32'(b_stall_cnt), (c < 7) ? c : 7);
        end

        // Ordering under random back-pressure against a FIFO model
        @(negedge clk); a_rst = 1; a_in_valid = 0; a_out_ready = 0;
        @(negedge clk); a_rst = 0;
        seq_data = 32'h1000;
        got = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            a_in_valid  = (c < 250) ? 1'($urandom_range(0, 1)) : 1'b0;
            a_in_data   = seq_data;
            a_out_ready = 1'($urandom_range(0, 3) != 0);
            #1;
            if (a_out_valid && a_out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", c, a_out_data, 32'hDEAD_BEEF);
                else check("order", c, a_out_data, exp_q.pop_front());
                got++;
            end
            if (a_in_valid && a_in_ready) begin
                exp_q.push_back(seq_data);
                seq_data = seq_data + 1;
            end
            @(posedge clk); #1;
            if (c % 25 == 0) check("occ_model", c, 32'(a_occ), exp_q.size());
        end
        check("drained", 0, exp_q.size(), 0);
        check("beats_out", 0, got, seq_data - 32'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
